gsim_result_buffer: RTL and testbench
=====================================

# gsim_result_buffer

Downstream collector for the Gauss-Seidel solver output stream. It captures each 16-word solution frame (Q16.16 signed words) into a ping-pong buffer and replays it to a consumer over a valid/ready handshake. The solver cannot stall, so the buffer lets the solver write the next frame while the previous one drains. An optional rounding/saturation stage converts each word to a sign-extended 16-bit integer.

## Interface
- Parameters:
- DEPTH, 16, words per frame (power of two; index width = log2(DEPTH))
- DW, 32, data width of input and output words
- Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high; one clock, one synchronous active-high reset
- in_valid  input  1  solver output strobe (solver out_valid); no backpressure
- in_data  input  DW  solver word (x_out), Q16.16 signed
- out_valid  output  1  out_data/out_idx/out_last valid
- out_ready  input  1  consumer accepts word when high with out_valid
- out_data  output  DW  buffered word (raw or rounded, see Configuration)
- out_idx  output  4  position of word within frame, 0..15
- out_last  output  1  high with the word where out_idx == 15
- err_overflow  output  1  sticky: a frame was dropped because both banks were full

## Operation
- Storage: two banks of DEPTH×DW words; each bank has a full flag.
- Write side: wr_bank, wr_cnt[3:0]. Each cycle with in_valid high writes in_data to bank[wr_bank][wr_cnt], then wr_cnt increments. Gaps in in_valid are allowed; wr_cnt holds during gaps.
- On the beat where wr_cnt == 15, wr_cnt wraps to 0, bank[wr_bank].full sets, and wr_bank toggles.
- Drop rule: on a beat with wr_cnt == 0 and bank[wr_bank].full == 1, set drop_frame. All 16 beats of that frame are discarded: wr_cnt still advances, but there are no writes and no full-set. On the 16th beat, wr_bank stays unchanged and drop_frame clears. err_overflow sets on the first dropped beat and holds until reset.
- Read side FSM states:
  - IDLE: out_valid = 0. If bank[rd_bank].full, load word 0 and go to SEND.
  - SEND: present bank[rd_bank][rd_cnt]. On out_valid && out_ready, advance rd_cnt and load the next word. On the handshake of word 15, clear bank[rd_bank].full, toggle rd_bank, set rd_cnt = 0, and go to IDLE.
- Simultaneous events: a full-set on the write side and a full-clear on the read side in the same cycle target different banks by construction. Both take effect.
- Reset mid-frame discards all partial and full frames; both banks become empty.

## Timing
- Reset values: out_valid 0, out_data 0, out_idx 0, out_last 0, err_overflow 0, both full flags 0, wr_bank = rd_bank = 0, wr_cnt = rd_cnt = 0, FSM in IDLE.
- Input-to-output latency: bank full set at edge N (16th beat). IDLE sees full in cycle N+1, and word 0 is registered out with out_valid high from edge N+2.
- Output registers hold stable while out_valid && !out_ready.
- Throughput: one word per cycle while out_ready is high. Exactly one idle cycle (out_valid low) between consecutive frames (SEND→IDLE→SEND).
- A full frame drains in 16 cycles at out_ready = 1, and the solver's minimum frame period is longer, so steady state never overflows. Overflow occurs only under consumer stall.

## Configuration
- Macro GSIM_RESBUF_ROUND_EN.
- Defined:
  - out_data = sign-extended 16-bit value of round(in_word).
  - Computed in 33 bits: (word + 0x8000) >>> 16, i.e. round half up.
  - Saturated to [-32768, 32767], then sign-extended to DW.
- Undefined: out_data is the stored word unchanged; the rounding logic is absent.
- Buffering, handshake and latency are identical in both builds.

## Test plan
- Reset, then 16 back-to-back in_valid beats with data = 0x0001_0000×i and out_ready = 1 → out_valid rises 2 cycles after the last beat. Raw build: out_data = 0x0001_0000×idx for idx 0..15, with out_last only on idx 15.
- Same frame with in_valid toggling every other cycle → identical output sequence, one frame, no err_overflow.
- out_ready = 0 while 3 frames arrive → frames 1 and 2 buffered and frame 3 dropped. err_overflow rises on the first beat of frame 3. Releasing out_ready then yields exactly 32 words: frame 1, one idle cycle, frame 2.
- Random out_ready stalls mid-frame → out_data/out_idx stable during every stall; no word lost or duplicated.
- ROUND_EN build with inputs 0x0001_8000, 0xFFFF_8000, 0x7FFF_FFFF, 0x8000_0000, 0x0000_7FFF → out_data 0x0000_0002, 0x0000_0000, 0x0000_7FFF, 0xFFFF_8000, 0x0000_0000.
- Assert reset at the 10th beat of a frame and during SEND → next cycle out_valid = 0 and all flags clear. A fresh 16-beat frame then drains normally from idx 0.

Source files
------------

// File: rtl/gsim_result_buffer_if.sv
// Handshake bundle between the Gauss-Seidel solver, the result buffer
// and the downstream consumer.
interface gsim_result_buffer_if #(
    parameter int DW = 32,
    parameter int IW = 4
);
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [IW-1:0] out_idx;
    logic          out_last;
    logic          err_overflow;

    // Environment side: solver and consumer
    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  out_valid,
        input  out_data,
        input  out_idx,
        input  out_last,
        input  err_overflow
    );

    // Buffer side
    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output out_valid,
        output out_data,
        output out_idx,
        output out_last,
        output err_overflow
    );
endinterface

// File: rtl/gsim_result_buffer.sv
// Ping-pong frame buffer for the Gauss-Seidel solver output stream.
// Macro GSIM_RESBUF_ROUND_EN adds Q16.16 -> int16 round/saturate.
module gsim_result_buffer #(
    parameter int DEPTH = 16,
    parameter int DW    = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    gsim_result_buffer_if.slave  bus
);
    localparam int IW = $clog2(DEPTH);
    localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    logic [DW-1:0] mem [2][DEPTH];

    logic [1:0]    full;
    logic [1:0]    full_q;
    logic          wr_bank;
    logic [IW-1:0] wr_cnt;
    logic          drop_frame;
    logic          err_q;

    state_t        state;
    logic          rd_bank;
    logic [IW-1:0] rd_cnt;
    logic          out_valid_q;
    logic [DW-1:0] out_data_q;
    logic [IW-1:0] out_idx_q;
    logic          out_last_q;

    logic          drop_start;
    logic          dropping;
    logic          wr_en;
    logic          wr_set;
    logic          rd_done;
    logic [IW-1:0] rd_nxt;
    logic [DW-1:0] rd_word;

`ifdef GSIM_RESBUF_ROUND_EN
    localparam logic signed [DW:0] HALF = (DW + 1)'(32768);

    function automatic logic [DW-1:0] fmt(input logic [DW-1:0] w);
        logic signed [DW:0] s;
        logic signed [DW:0] q;
        logic [15:0]        r;
        s = $signed({w[DW-1], w}) + HALF;
        q = s >>> 16;
        if (&q[DW:15] || ~|q[DW:15]) begin
            r = q[15:0];
        end else begin
            r = q[DW] ? 16'h8000 : 16'h7fff;
        end
        return {{(DW - 16){r[15]}}, r};
    endfunction
`else
    function automatic logic [DW-1:0] fmt(input logic [DW-1:0] w);
        return w;
    endfunction
`endif

    // Beat qualification: drop decision, write enable, bank-complete
    always_comb begin
        drop_start = bus.in_valid && (wr_cnt == '0) && full[wr_bank];
        dropping   = drop_frame || drop_start;
        wr_en      = bus.in_valid && !dropping;
        wr_set     = wr_en && (wr_cnt == LAST);
        rd_done    = (state == SEND) && bus.out_ready && (rd_cnt == LAST);
        rd_nxt     = (state == SEND) ? rd_cnt + 1'b1 : '0;
        rd_word    = fmt(mem[rd_bank][rd_nxt]);
    end

    // Frame storage, no reset so it maps onto RAM
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_bank][wr_cnt] <= bus.in_data;
        end
    end

    // Write pointer, frame drop and sticky overflow flag
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_bank    <= 1'b0;
            wr_cnt     <= '0;
            drop_frame <= 1'b0;
            err_q      <= 1'b0;
        end else if (bus.in_valid) begin
            wr_cnt <= wr_cnt + 1'b1;
            if (drop_start) begin
                drop_frame <= 1'b1;
                err_q      <= 1'b1;
            end
            if (wr_cnt == LAST) begin
                drop_frame <= 1'b0;
                if (!dropping) begin
                    wr_bank <= ~wr_bank;
                end
            end
        end
    end

    // Bank full flags; set and clear always hit different banks
    always_ff @(posedge clk) begin
        if (reset) begin
            full   <= '0;
            full_q <= '0;
        end else begin
            full_q <= full;
            if (rd_done) begin
                full[rd_bank] <= 1'b0;
            end
            if (wr_set) begin
                full[wr_bank] <= 1'b1;
            end
        end
    end

    // Read FSM with registered output word, index and last flag
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            rd_bank     <= 1'b0;
            rd_cnt      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (full_q[rd_bank] && full[rd_bank]) begin
                        state       <= SEND;
                        rd_cnt      <= '0;
                        out_valid_q <= 1'b1;
                        out_data_q  <= rd_word;
                        out_idx_q   <= '0;
                        out_last_q  <= (rd_nxt == LAST);
                    end
                end
                SEND: begin
                    if (bus.out_ready) begin
                        if (rd_cnt == LAST) begin
                            state       <= IDLE;
                            rd_bank     <= ~rd_bank;
                            rd_cnt      <= '0;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                        end else begin
                            rd_cnt      <= rd_nxt;
                            out_data_q  <= rd_word;
                            out_idx_q   <= rd_nxt;
                            out_last_q  <= (rd_nxt == LAST);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.out_valid    = out_valid_q;
    assign bus.out_data     = out_data_q;
    assign bus.out_idx      = out_idx_q;
    assign bus.out_last     = out_last_q;
    assign bus.err_overflow = err_q;

endmodule

// File: tb/tb_gsim_result_buffer.sv
// Directed bench for gsim_result_buffer: latency, gaps, overflow,
// stalls, rounding vectors and mid-frame reset.
module tb_gsim_result_buffer;
    logic clk = 1'b0;
    logic reset;

    gsim_result_buffer_if #(.DW(32), .IW(4)) bif ();

    gsim_result_buffer #(.DEPTH(16), .DW(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  idx;
        logic        last;
        int          cyc;
    } word_t;

    word_t q[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic prev_stall = 1'b0;
    logic prev_rst = 1'b1;
    logic [31:0] hd;
    logic [3:0] hi;

    logic [31:0] rv [5] = '{32'h0001_8000, 32'hFFFF_8000,
                            32'h7FFF_FFFF, 32'h8000_0000,
                            32'h0000_7FFF};
`ifdef GSIM_RESBUF_ROUND_EN
    logic [31:0] re [5] = '{32'h0000_0002, 32'h0000_0000,
                            32'h0000_7FFF, 32'hFFFF_8000,
                            32'h0000_0000};
`else
    logic [31:0] re [5] = '{32'h0001_8000, 32'hFFFF_8000,
                            32'h7FFF_FFFF, 32'h8000_0000,
                            32'h0000_7FFF};
`endif

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] fw(input int k, input int i);
        logic [31:0] v;
        v = 32'(i + 16 * k) << 16;
        return v;
    endfunction

    function automatic logic [31:0] ex(input int k, input int i);
`ifdef GSIM_RESBUF_ROUND_EN
        return 32'(i + 16 * k);
`else
        return fw(k, i);
`endif
    endfunction

    always @(posedge clk) cyc++;

    // Output monitor: records handshakes, checks hold during stalls
    always @(negedge clk) begin
        if (prev_stall && !prev_rst) begin
            check("hold_v", 32'(bif.out_valid), 32'd1);
            check("hold_d", bif.out_data, hd);
            check("hold_i", 32'(bif.out_idx), 32'(hi));
        end
        prev_rst = reset;
        prev_stall = bif.out_valid && !bif.out_ready;
        hd = bif.out_data;
        hi = bif.out_idx;
        if (bif.out_valid && bif.out_ready && !reset) begin
            q.push_back('{bif.out_data, bif.out_idx, bif.out_last, cyc});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [31:0] d, input int gap);
        bif.in_valid = 1'b1;
        bif.in_data = d;
        step();
        bif.in_valid = 1'b0;
        repeat (gap) step();
    endtask

    task automatic send_frame(input int k, input int gap);
        for (int i = 0; i < 16; i++) beat(fw(k, i), gap);
    endtask

    task automatic drain(input int n);
        int c;
        c = 0;
        while (q.size() < n && c < 300) begin
            step();
            c++;
        end
        repeat (4) step();
        check("count", 32'(q.size()), 32'(n));
    endtask

    task automatic check_frame(input int off, input int k);
        for (int i = 0; i < 16; i++) begin
            check("data", q[off+i].d, ex(k, i));
            check("idx", 32'(q[off+i].idx), 32'(i));
            check("last", 32'(q[off+i].last), 32'(i == 15));
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        bif.in_valid = 1'b0;
        bif.in_data = '0;
        bif.out_ready = 1'b1;
        repeat (3) step();
        check("rst_valid", 32'(bif.out_valid), 32'd0);
        check("rst_data", bif.out_data, 32'd0);
        check("rst_idx", 32'(bif.out_idx), 32'd0);
        check("rst_last", 32'(bif.out_last), 32'd0);
        check("rst_err", 32'(bif.err_overflow), 32'd0);
        reset = 1'b0;
        step();

        // Back-to-back frame, latency of two cycles after last beat
        q.delete();
        send_frame(0, 0);
        check("lat0", 32'(bif.out_valid), 32'd0);
        step();
        check("lat1", 32'(bif.out_valid), 32'd0);
        step();
        check("lat2", 32'(bif.out_valid), 32'd1);
        check("lat2_idx", 32'(bif.out_idx), 32'd0);
        drain(16);
        check_frame(0, 0);

        // Gapped input gives the same frame
        q.delete();
        send_frame(1, 1);
        drain(16);
        check_frame(0, 1);
        check("gap_err", 32'(bif.err_overflow), 32'd0);

        // Consumer stalled while three frames arrive
        q.delete();
        bif.out_ready = 1'b0;
        send_frame(1, 0);
        send_frame(2, 0);
        check("ovf_pre", 32'(bif.err_overflow), 32'd0);
        beat(fw(3, 0), 0);
        check("ovf_rise", 32'(bif.err_overflow), 32'd1);
        for (int i = 1; i < 16; i++) beat(fw(3, i), 0);
        repeat (3) step();
        check("stall_cnt", 32'(q.size()), 32'd0);
        bif.out_ready = 1'b1;
        drain(32);
        check_frame(0, 1);
        check_frame(16, 2);
        check("idle_gap", 32'(q[16].cyc - q[15].cyc), 32'd2);
        check("ovf_sticky", 32'(bif.err_overflow), 32'd1);

        // Reset at the 10th beat while a frame sits in SEND
        q.delete();
        bif.out_ready = 1'b0;
        send_frame(3, 0);
        repeat (3) step();
        check("pre_rst_v", 32'(bif.out_valid), 32'd1);
        for (int i = 0; i < 9; i++) beat(fw(0, i), 0);
        bif.in_valid = 1'b1;
        bif.in_data = fw(0, 9);
        reset = 1'b1;
        step();
        reset = 1'b0;
        bif.in_valid = 1'b0;
        check("post_rst_v", 32'(bif.out_valid), 32'd0);
        check("post_rst_d", bif.out_data, 32'd0);
        check("post_rst_i", 32'(bif.out_idx), 32'd0);
        check("post_rst_l", 32'(bif.out_last), 32'd0);
        check("post_rst_e", 32'(bif.err_overflow), 32'd0);
        bif.out_ready = 1'b1;
        step();
        q.delete();
        send_frame(0, 0);
        drain(16);
        check_frame(0, 0);

        // Rounding/saturation corner vectors
        q.delete();
        for (int i = 0; i < 16; i++) beat((i < 5) ? rv[i] : 32'd0, 0);
        drain(16);
        for (int i = 0; i < 5; i++) check("round", q[i].d, re[i]);
        check("round_z", q[10].d, 32'd0);

        // Random consumer stalls mid-frame
        q.delete();
        bif.out_ready = 1'b0;
        send_frame(2, 0);
        repeat (3) step();
        for (int c = 0; c < 300 && q.size() < 16; c++) begin
            bif.out_ready = 1'($urandom_range(0, 1));
            step();
        end
        bif.out_ready = 1'b1;
        repeat (4) step();
        check("rand_cnt", 32'(q.size()), 32'd16);
        check_frame(0, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
